operator_unit: RTL and testbench

- Parameterised signed multi-function ALU operator block: computes all eleven results (mov, compare, add, sub, mul, div, xor, and, not, shl, shr) of two signed N-bit operands in parallel.
- The execute stage selects the required result downstream; this block does no opcode decode.
- All results are registered, giving a single pipeline stage with one-cycle latency.

---
 rtl/operator_pkg.sv | 19 +
 rtl/operator_div.sv | 29 ++
 rtl/operator_unit.sv | 130 +++++++++++++
 tb/tb_operator_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/operator_pkg.sv
// operator_pkg: shared constants and helpers for the operator_unit ALU slice.
// Constants are held at 32 bits and sliced to the operand width N by users.
package operator_pkg;

   // Three-way compare results, sign-extended so any low slice stays correct
   localparam logic [31:0] CMP_GT = 32'h0000_0001;
   localparam logic [31:0] CMP_EQ = 32'h0000_0000;
   localparam logic [31:0] CMP_LT = 32'hFFFF_FFFF;

   // Quotient returned for a zero divisor (all ones, i.e. -1)
   localparam logic [31:0] DIV_BY_ZERO = 32'hFFFF_FFFF;

   // True when a shift amount pushes every operand bit out of the word
   function automatic logic shamt_saturates(input logic [31:0] amt,
                                            input logic [31:0] width);
      return (amt >= width);
   endfunction

endpackage

// File: rtl/operator_div.sv
// operator_div: combinational signed divider, quotient truncated toward zero.
// Only instantiated when OPERATOR_DIV_EN is defined.
// Zero divisor yields -1; the most-negative / -1 case wraps to most-negative.
module operator_div
   import operator_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] q
);

   localparam logic [N-1:0] MIN_NEG  = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

   // Quotient selection with the two special cases resolved first
   always_comb begin
      q = '0;
      if (b == '0) begin
         q = DIV_BY_ZERO[N-1:0];
      end else if ((a == MIN_NEG) && (b == ALL_ONES)) begin
         q = MIN_NEG;
      end else begin
         q = $signed(a) / $signed(b);
      end
   end

endmodule

// File: rtl/operator_unit.sv
// operator_unit: computes every ALU result of two signed N-bit operands in
// parallel and registers them, giving a single stage with one-cycle latency.
// Opcode selection happens downstream.
// Optional feature macro: OPERATOR_DIV_EN (when undefined, r_div is always 0).
module operator_unit
   import operator_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   output logic [N-1:0] r_mov,
   output logic [N-1:0] r_compare,
   output logic [N-1:0] r_add,
   output logic [N-1:0] r_sub,
   output logic [N-1:0] r_mul,
   output logic [N-1:0] r_div,
   output logic [N-1:0] r_xor,
   output logic [N-1:0] r_and,
   output logic [N-1:0] r_not,
   output logic [N-1:0] r_shl,
   output logic [N-1:0] r_shr
);

   logic signed [N-1:0] a_sg_s;
   logic signed [N-1:0] b_sg_s;
   logic [N-1:0] cmp_s, add_s, sub_s, mul_s, div_s;
   logic [N-1:0] shl_s, shr_s;

   logic         valid_r;
   logic [N-1:0] mov_r, cmp_r, add_r, sub_r, mul_r, div_r;
   logic [N-1:0] xor_r, and_r, not_r, shl_r, shr_r;

   assign a_sg_s = a;
   assign b_sg_s = b;

   // Add, subtract and multiply wrap modulo 2^N. The low N bits of a product
   // do not depend on signedness, so an N-bit multiply gives them directly.
   assign add_s = a + b;
   assign sub_s = a - b;
   assign mul_s = a * b;

   // Signed three-way compare
   always_comb begin
      cmp_s = CMP_EQ[N-1:0];
      if (a_sg_s > b_sg_s) begin
         cmp_s = CMP_GT[N-1:0];
      end else if (a_sg_s == b_sg_s) begin
         cmp_s = CMP_EQ[N-1:0];
      end else begin
         cmp_s = CMP_LT[N-1:0];
      end
   end

   // Shifts by the raw unsigned pattern of b; oversize amounts saturate
   always_comb begin
      shl_s = '0;
      shr_s = '0;
      if (shamt_saturates(32'(b), 32'(N))) begin
         shl_s = '0;
         shr_s = {N{a[N-1]}};
      end else begin
         shl_s = a << b;
         shr_s = a_sg_s >>> b;
      end
   end

`ifdef OPERATOR_DIV_EN
   operator_div #(
      .N (N)
   ) u_div (
      .a (a),
      .b (b),
      .q (div_s)
   );
`else
   assign div_s = '0;
`endif

   // Result bank: reset clears, valid loads, otherwise results hold
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         mov_r   <= '0;
         cmp_r   <= '0;
         add_r   <= '0;
         sub_r   <= '0;
         mul_r   <= '0;
         div_r   <= '0;
         xor_r   <= '0;
         and_r   <= '0;
         not_r   <= '0;
         shl_r   <= '0;
         shr_r   <= '0;
      end else if (in_valid) begin
         valid_r <= 1'b1;
         mov_r   <= b;
         cmp_r   <= cmp_s;
         add_r   <= add_s;
         sub_r   <= sub_s;
         mul_r   <= mul_s;
         div_r   <= div_s;
         xor_r   <= a ^ b;
         and_r   <= a & b;
         not_r   <= ~a;
         shl_r   <= shl_s;
         shr_r   <= shr_s;
      end else begin
         valid_r <= 1'b0;
      end
   end

   assign out_valid = valid_r;
   assign r_mov     = mov_r;
   assign r_compare = cmp_r;
   assign r_add     = add_r;
   assign r_sub     = sub_r;
   assign r_mul     = mul_r;
   assign r_div     = div_r;
   assign r_xor     = xor_r;
   assign r_and     = and_r;
   assign r_not     = not_r;
   assign r_shl     = shl_r;
   assign r_shr     = shr_r;

endmodule

// File: tb/tb_operator_unit.sv
// tb_operator_unit: directed vectors with hand-computed results for N=4.
// Honours OPERATOR_DIV_EN for the expected quotient.
module tb_operator_unit;

   localparam int N = 4;

`ifdef OPERATOR_DIV_EN
   localparam logic DIV_ON = 1'b1;
`else
   localparam logic DIV_ON = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic [N-1:0] a, b;
   logic         out_valid;
   logic [N-1:0] r_mov, r_compare, r_add, r_sub, r_mul, r_div;
   logic [N-1:0] r_xor, r_and, r_not, r_shl, r_shr;

   int pass_cnt = 0;
   int total_cnt = 0;

   operator_unit #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .r_mov     (r_mov),
      .r_compare (r_compare),
      .r_add     (r_add),
      .r_sub     (r_sub),
      .r_mul     (r_mul),
      .r_div     (r_div),
      .r_xor     (r_xor),
      .r_and     (r_and),
      .r_not     (r_not),
      .r_shl     (r_shl),
      .r_shr     (r_shr)
   );

   // Free-running clock, 10 time-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Row layout (hex digits, MSB first):
   // a b mov cmp add sub mul div xor and not shl shr
   localparam int NV = 9;
   logic [51:0] vecs [NV] = '{
      52'h233F5F6012D00,  // a=2  b=3
      52'h3221516112CC0,  // a=3  b=2
      52'h71118677618E3,  // a=7  b=1   add wraps to -8
      52'h3330609103C80,  // a=3  b=3   mul wraps to -7, cmp 0
      52'h8FFF79887870F,  // a=-8 b=-1  div overflow, shift amount 15
      52'h5001550F50A55,  // a=5  b=0   divide by zero
      52'h811F97889070C,  // a=-8 b=1   shr sign-fills
      52'h922FB72DB064E,  // a=-7 b=2   div truncates toward zero (-3)
      52'h6CC12A8FA4900   // a=6  b=-4  div -1, shift saturates
   };

   string names [11] = '{"mov", "cmp", "add", "sub", "mul", "div",
                         "xor", "and", "not", "shl", "shr"};

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end else begin
         pass_cnt++;
      end
   endtask

   function automatic logic [N-1:0] out_sel(input int k);
      case (k)
         0:       return r_mov;
         1:       return r_compare;
         2:       return r_add;
         3:       return r_sub;
         4:       return r_mul;
         5:       return r_div;
         6:       return r_xor;
         7:       return r_and;
         8:       return r_not;
         9:       return r_shl;
         default: return r_shr;
      endcase
   endfunction

   task automatic check_row(input string ctx, input logic [51:0] row,
                            input logic exp_valid);
      logic [N-1:0] exp_v;
      check_eq({ctx, " out_valid"}, 32'(out_valid), 32'(exp_valid));
      for (int k = 0; k < 11; k++) begin
         exp_v = row[43 - 4*k -: 4];
         if (k == 5 && !DIV_ON) exp_v = 4'h0;
         check_eq({ctx, " ", names[k]}, 32'(out_sel(k)), 32'(exp_v));
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic [N-1:0] av,
                        input logic [N-1:0] bv);
      @(negedge clk);
      rst      = r;
      in_valid = v;
      a        = av;
      b        = bv;
      @(posedge clk);
      #1;
   endtask

   // Directed sequence: reset, vectors, hold, reset-over-valid
   initial begin
      logic [51:0] row;
      rst      = 1'b1;
      in_valid = 1'b0;
      a        = 4'h0;
      b        = 4'h0;
      drive(1'b1, 1'b0, 4'h0, 4'h0);
      drive(1'b1, 1'b0, 4'h0, 4'h0);
      drive(1'b0, 1'b0, 4'h0, 4'h0);
      check_row("reset", 52'h0, 1'b0);

      for (int i = 0; i < NV; i++) begin
         row = vecs[i];
         drive(1'b0, 1'b1, row[51:48], row[47:44]);
         check_row($sformatf("vec%0d", i), row, 1'b1);
      end

      // Hold: new operands without in_valid must not disturb the results
      drive(1'b0, 1'b0, 4'h1, 4'h1);
      check_row("hold", vecs[NV-1], 1'b0);
      drive(1'b0, 1'b0, 4'h2, 4'h7);
      check_row("hold2", vecs[NV-1], 1'b0);

      // Reset wins over a simultaneous valid pair
      drive(1'b0, 1'b1, 4'h3, 4'h2);
      check_row("pre_rst", vecs[1], 1'b1);
      drive(1'b1, 1'b1, 4'h7, 4'h1);
      check_row("rst_valid", 52'h0, 1'b0);

      // Recovery after reset
      drive(1'b0, 1'b1, 4'h2, 4'h3);
      check_row("after_rst", vecs[0], 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
